// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive paths.
// Includes the frame state encoding and the character parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int UART_OVERSAMPLE = 16;

    localparam logic [3:0] NBITS_MIN = 4'd5;
    localparam logic [3:0] NBITS_MAX = 4'd8;

    // Parity over the low nbits of data only; odd=1 selects odd parity.
    function automatic logic parity_calc(
        input logic [15:0] data,
        input logic [3:0]  nbits,
        input logic        odd
    );
        logic p;
        p = odd;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(nbits)) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// Bit-period timer: counts OVERSAMPLE Tick strobes per bit while enabled.
// o_bit_end is high on the Tick that wraps the count back to zero.
module uart_tick_counter
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_en,
    input  logic i_tick,
    output logic o_bit_end
);

    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

    logic [3:0] r_cnt;

    assign o_bit_end = i_en && i_tick && (r_cnt == LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= 4'd0;
        end else if (!i_en) begin
            r_cnt <= 4'd0;
        end else if (i_tick) begin
            r_cnt <= o_bit_end ? 4'd0 : r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/uart_rs232_tx.sv
// RS-232 transmitter: start, 5-8 data bits LSB first, optional parity,
// 1 or 2 stop bits, timed from the shared oversampling Tick strobe.
module uart_rs232_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_W     = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              TxEn,
    input  logic              TxStart,
    input  logic [DATA_W-1:0] TxData,
    input  logic [3:0]        NBits,
    input  logic              ParityEn,
    input  logic              ParityOdd,
    input  logic              StopBits2,
    input  logic              Tick,
    output logic              Tx,
    output logic              TxBusy,
    output logic              TxDone
);

    tx_state_t         r_state;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;
    logic [3:0]        r_bitcnt;
    logic [3:0]        r_nbits;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_en;
    logic              r_par;
    logic              r_stop2;

    logic              w_bit_end;
    logic [3:0]        w_nbits;
    logic              w_accept;

    assign w_nbits  = (NBits >= NBITS_MIN && NBits <= NBITS_MAX)
                    ? NBits : NBITS_MAX;
    assign w_accept = (r_state == IDLE) && TxStart && TxEn;

    assign Tx     = r_tx;
    assign TxBusy = r_busy;
    assign TxDone = r_done;

    uart_tick_counter #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_counter (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .i_en      (r_state != IDLE),
        .i_tick    (Tick),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= IDLE;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bitcnt <= 4'd0;
            r_nbits  <= NBITS_MAX;
            r_shift  <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_stop2  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_bitcnt <= 4'd0;
                        r_nbits  <= w_nbits;
                        r_shift  <= TxData;
                        r_par_en <= ParityEn;
                        r_par    <= parity_calc(16'(TxData), w_nbits, ParityOdd);
                        r_stop2  <= StopBits2;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state  <= DATA;
                        r_tx     <= r_shift[0];
                        r_bitcnt <= 4'd0;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (r_bitcnt == r_nbits - 4'd1) begin
                            r_bitcnt <= 4'd0;
                            if (r_par_en) begin
                                r_state <= PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                            r_tx     <= r_shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_state  <= STOP;
                        r_tx     <= 1'b1;
                        r_bitcnt <= 4'd0;
                    end
                end
                STOP: begin
                    // r_bitcnt marks the first of two stop bits as done
                    if (w_bit_end) begin
                        if (r_stop2 && r_bitcnt == 4'd0) begin
                            r_bitcnt <= 4'd1;
                        end else begin
                            r_state  <= IDLE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_bitcnt <= 4'd0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rs232_tx.sv
// Directed bench for uart_rs232_tx with a frame scoreboard and a
// line monitor that samples every bit in the middle of its period.
module tb_uart_rs232_tx;

    localparam int OS = 16;

    logic       Clk;
    logic       Rst_n;
    logic       TxEn;
    logic       TxStart;
    logic [7:0] TxData;
    logic [3:0] NBits;
    logic       ParityEn;
    logic       ParityOdd;
    logic       StopBits2;
    logic       Tick;
    logic       Tx;
    logic       TxBusy;
    logic       TxDone;

    typedef struct {
        logic [7:0] d;
        int         n;
        bit         pe;
        bit         od;
        bit         s2;
    } frm_t;

    frm_t sbq[$];

    int checks     = 0;
    int failures   = 0;
    int done_cnt   = 0;
    int busy_ticks = 0;
    int mon_tk     = 0;
    int tick_div   = 4;
    int tick_ph    = 0;

    uart_rs232_tx #(
        .OVERSAMPLE (OS),
        .DATA_W     (8)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .TxEn      (TxEn),
        .TxStart   (TxStart),
        .TxData    (TxData),
        .NBits     (NBits),
        .ParityEn  (ParityEn),
        .ParityOdd (ParityOdd),
        .StopBits2 (StopBits2),
        .Tick      (Tick),
        .Tx        (Tx),
        .TxBusy    (TxBusy),
        .TxDone    (TxDone)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Tick changes 2ns after posedge, stable at both sampling edges
    initial begin
        Tick = 1'b0;
        forever begin
            @(posedge Clk);
            #2;
            if (tick_div <= 1) begin
                Tick = 1'b1;
            end else begin
                tick_ph = (tick_ph + 1) % tick_div;
                Tick = (tick_ph == 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (TxDone === 1'b1) done_cnt++;
            if (TxBusy === 1'b1 && Tick === 1'b1) busy_ticks++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line monitor: pops the expected frame when a start bit appears
    initial begin : monitor
        frm_t       f;
        logic       e [12];
        logic [7:0] rx;
        logic [7:0] msk;
        logic       p;
        int         tot;
        int         tk;
        int         b;
        bit         ab;
        forever begin
            @(negedge Clk);
            if (Rst_n === 1'b1 && Tx === 1'b0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL unexpected_frame observed=start expected=idle");
                    for (int k = 0; k < 5000; k++) begin
                        @(negedge Clk);
                        if (TxBusy !== 1'b1) break;
                    end
                end else begin
                    f = sbq.pop_front();
                    for (int i = 0; i < 12; i++) e[i] = 1'b1;
                    e[0] = 1'b0;
                    p = f.od;
                    for (int i = 0; i < f.n; i++) begin
                        e[1+i] = f.d[i];
                        p = p ^ f.d[i];
                    end
                    tot = 1 + f.n;
                    if (f.pe) begin
                        e[tot] = p;
                        tot++;
                    end
                    tot += f.s2 ? 2 : 1;
                    tk = 0;
                    ab = 1'b1;
                    rx = 8'h00;
                    mon_tk = 0;
                    for (int k = 0; k < 20000; k++) begin
                        if (Rst_n !== 1'b1) break;
                        if (Tick === 1'b1) begin
                            tk++;
                            mon_tk = tk;
                            if (tk % OS == OS / 2) begin
                                b = tk / OS;
                                chk($sformatf("bit%0d", b), 32'(Tx), 32'(e[b]));
                                chk("busy_mid", 32'(TxBusy), 32'd1);
                                if (b >= 1 && b <= f.n) rx[b-1] = Tx;
                            end
                            if (tk == tot * OS) begin
                                ab = 1'b0;
                                break;
                            end
                        end
                        @(negedge Clk);
                    end
                    if (!ab) begin
                        @(negedge Clk);
                        msk = 8'hFF >> (8 - f.n);
                        chk("char", 32'(rx), 32'(f.d & msk));
                        chk("done_pulse", 32'(TxDone), 32'd1);
                        chk("busy_end", 32'(TxBusy), 32'd0);
                        chk("tx_gap", 32'(Tx), 32'd1);
                    end else if (Rst_n === 1'b1) begin
                        checks++;
                        failures++;
                        $error("FAIL frame_timeout observed=%0d expected=%0d",
                               tk, tot * OS);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [3:0] nb,
                        input int en, input bit pe, input bit od,
                        input bit s2);
        TxData    = d;
        NBits     = nb;
        ParityEn  = pe;
        ParityOdd = od;
        StopBits2 = s2;
        TxEn      = 1'b1;
        TxStart   = 1'b1;
        sbq.push_back('{d, en, pe, od, s2});
        @(negedge Clk);
        TxStart = 1'b0;
        chk("accept_tx", 32'(Tx), 32'd0);
        chk("accept_busy", 32'(TxBusy), 32'd1);
        // Scramble config: the frame in flight must not notice
        TxData    = ~d;
        NBits     = 4'd5;
        ParityEn  = ~pe;
        ParityOdd = ~od;
        StopBits2 = ~s2;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge Clk);
            if (TxDone === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $error("FAIL %s observed=no_done expected=done", tag);
        end
    endtask

    initial begin : main
        int d0;
        bit hit;
        Rst_n     = 1'b1;
        TxEn      = 1'b0;
        TxStart   = 1'b0;
        TxData    = 8'h00;
        NBits     = 4'd8;
        ParityEn  = 1'b0;
        ParityOdd = 1'b0;
        StopBits2 = 1'b0;
        #1 Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_tx", 32'(Tx), 32'd1);
        chk("rst_busy", 32'(TxBusy), 32'd0);
        chk("rst_done", 32'(TxDone), 32'd0);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);

        // 8N1 0x55, Tick every 4 Clk
        tick_div   = 4;
        busy_ticks = 0;
        send(8'h55, 4'd8, 8, 1'b0, 1'b0, 1'b0);
        wait_done("done_8n1");
        repeat (3) @(negedge Clk);
        chk("busy_ticks_8n1", 32'(busy_ticks), 32'd160);
        chk("done_cnt_8n1", 32'(done_cnt), 32'd1);

        // 7E1 0xC1, Tick every 3 Clk
        tick_div = 3;
        send(8'hC1, 4'd7, 7, 1'b1, 1'b0, 1'b0);
        wait_done("done_7e1");
        repeat (3) @(negedge Clk);

        // 8O2 0x00, Tick held high
        tick_div   = 1;
        busy_ticks = 0;
        send(8'h00, 4'd8, 8, 1'b1, 1'b1, 1'b1);
        wait_done("done_8o2");
        repeat (3) @(negedge Clk);
        chk("busy_ticks_8o2", 32'(busy_ticks), 32'd192);
        chk("done_cnt_8o2", 32'(done_cnt), 32'd3);

        // Back-to-back, with an ignored mid-frame request and TxEn drop
        tick_div = 2;
        send(8'hA5, 4'd8, 8, 1'b0, 1'b0, 1'b0);
        repeat (100) @(negedge Clk);
        TxData  = 8'hFF;
        TxStart = 1'b1;
        @(negedge Clk);
        TxStart = 1'b0;
        repeat (100) @(negedge Clk);
        TxEn = 1'b0;
        wait_done("done_a5");
        send(8'h3C, 4'd8, 8, 1'b0, 1'b0, 1'b0);
        wait_done("done_3c");
        repeat (3) @(negedge Clk);
        chk("done_cnt_b2b", 32'(done_cnt), 32'd5);

        // TxStart with TxEn low is ignored
        TxEn    = 1'b0;
        TxStart = 1'b1;
        TxData  = 8'h0F;
        @(negedge Clk);
        TxStart = 1'b0;
        chk("noen_busy", 32'(TxBusy), 32'd0);
        chk("noen_tx", 32'(Tx), 32'd1);
        repeat (300) @(negedge Clk);
        chk("noen_done_cnt", 32'(done_cnt), 32'd5);

        // Reset in the middle of data bit 3
        tick_div = 1;
        send(8'h5A, 4'd8, 8, 1'b0, 1'b0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clk);
            if (mon_tk >= 4 * OS + OS / 2) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_data3", 32'(hit), 32'd1);
        d0 = done_cnt;
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_tx", 32'(Tx), 32'd1);
        chk("arst_busy", 32'(TxBusy), 32'd0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_tx", 32'(Tx), 32'd1);
        chk("post_rst_done", 32'(done_cnt), 32'(d0));

        // NBits=12 is sent as 8 bits
        send(8'h81, 4'd12, 8, 1'b0, 1'b0, 1'b0);
        wait_done("done_81");
        repeat (5) @(negedge Clk);
        chk("done_cnt_end", 32'(done_cnt), 32'd6);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
